// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I opcodes, ALU/writeback/state encodings and decode helpers
package rv32_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [31:0] RV32_NOP  = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_BRANCH,
    S_WRITEBACK,
    S_TRAP
  } ctrl_state_e;

  function automatic logic is_supported(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI};
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate decoder, sign-extended to XLEN
module imm_gen import rv32_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_ir,
  output logic [XLEN-1:0] o_imm
);
  logic [31:0] w_imm;
  // pick the immediate format implied by the opcode; formats without an immediate yield 0
  always_comb begin
    w_imm = '0;
    case (i_ir[6:0])
      OPC_OP_IMM, OPC_LOAD: w_imm = {{20{i_ir[31]}}, i_ir[31:20]};
      OPC_STORE:            w_imm = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
      OPC_BRANCH:           w_imm = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
      OPC_JAL:              w_imm = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
      OPC_LUI:              w_imm = {i_ir[31:12], 12'h000};
      default:              w_imm = '0;
    endcase
  end
  assign o_imm = XLEN'($signed(w_imm));
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle RV32I control FSM sequencing fetch, decode, execute, memory and writeback
module control_unit import rv32_pkg::*; #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = RV32_NOP
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            o_imem_req,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_pc_wen,
  output logic            o_calc_bj_addr,
  output logic            o_imm_sel,
  output logic [XLEN-1:0] o_immediate,
  output logic [3:0]      o_alu_op,
  input  logic            i_alu_zero,
  output logic [4:0]      o_rs1_addr,
  output logic [4:0]      o_rs2_addr,
  output logic [4:0]      o_rd_addr,
  output logic            o_rf_wen,
  output logic [1:0]      o_wb_sel,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [2:0]      o_mem_funct3,
  input  logic            i_dmem_ack,
  output logic            o_illegal
);
  ctrl_state_e r_state, w_next;
  logic [31:0] r_ir;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic        w_f7b5, w_is_store, w_is_mem, w_taken;
  logic [3:0]  w_alu_op;
  logic [1:0]  w_wb_sel;

  assign w_opc        = r_ir[6:0];
  assign w_f3         = r_ir[14:12];
  assign w_f7b5       = r_ir[30];
  assign w_is_store   = w_opc == OPC_STORE;
  assign w_is_mem     = w_is_store || w_opc == OPC_LOAD;
  assign w_taken      = i_alu_zero ^ (w_f3[0] ^ w_f3[2]);
  assign o_rs1_addr   = r_ir[19:15];
  assign o_rs2_addr   = r_ir[24:20];
  assign o_rd_addr    = r_ir[11:7];
  assign o_mem_funct3 = w_f3;
  assign o_imm_sel    = !(w_opc == OPC_OP || w_opc == OPC_BRANCH);
  assign o_alu_op     = w_alu_op;
  assign o_wb_sel     = w_wb_sel;
  assign o_illegal    = rstn && r_state == S_TRAP;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_ir  (r_ir),
    .o_imm (o_immediate)
  );

  // state register and IR; the IR only loads on an acknowledged fetch
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_FETCH;
      r_ir    <= NOP_INSTR;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && i_imem_ack) r_ir <= i_imem_rdata;
    end
  end

  // map opcode, funct3 and funct7[5] onto the execute-unit operation
  always_comb begin
    w_alu_op = ALU_ADD;
    if (w_opc == OPC_OP || w_opc == OPC_OP_IMM)
      case (w_f3)
        3'b000:  w_alu_op = (w_opc == OPC_OP && w_f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  w_alu_op = ALU_SLL;
        3'b010:  w_alu_op = ALU_SLT;
        3'b011:  w_alu_op = ALU_SLTU;
        3'b100:  w_alu_op = ALU_XOR;
        3'b101:  w_alu_op = w_f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  w_alu_op = ALU_OR;
        default: w_alu_op = ALU_AND;
      endcase
    else if (w_opc == OPC_BRANCH)
      w_alu_op = w_f3[2] ? (w_f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
  end

  // writeback source: load data, link address, upper immediate or ALU result
  always_comb begin
    w_wb_sel = WB_ALU;
    if (w_opc == OPC_LOAD) w_wb_sel = WB_MEM;
    else if (w_opc == OPC_JAL) w_wb_sel = WB_LINK;
    else if (w_opc == OPC_LUI) w_wb_sel = WB_IMM;
  end

  // next state and strobes; every strobe is forced low while reset is sampled
  always_comb begin
    w_next         = r_state;
    o_imem_req     = 1'b0;
    o_dmem_req     = 1'b0;
    o_dmem_we      = 1'b0;
    o_pc_wen       = 1'b0;
    o_calc_bj_addr = 1'b0;
    o_rf_wen       = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_supported(w_opc)) w_next = S_EXECUTE;
        else w_next = S_TRAP;
      end
      S_EXECUTE: begin
        if (w_opc == OPC_BRANCH) w_next = S_BRANCH;
        else if (w_is_mem) w_next = S_MEM;
        else w_next = S_WRITEBACK;
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = w_is_store;
        if (i_dmem_ack) begin
          o_pc_wen = w_is_store;
          if (w_is_store) w_next = S_FETCH;
          else w_next = S_WRITEBACK;
        end
      end
      S_BRANCH: begin
        o_pc_wen       = 1'b1;
        o_calc_bj_addr = w_taken;
        w_next         = S_FETCH;
      end
      S_WRITEBACK: begin
        o_pc_wen       = 1'b1;
        o_rf_wen       = |o_rd_addr;
        o_calc_bj_addr = w_opc == OPC_JAL;
        w_next         = S_FETCH;
      end
      default: w_next = S_TRAP;
    endcase
    if (!rstn) begin
      o_imem_req     = 1'b0;
      o_dmem_req     = 1'b0;
      o_dmem_we      = 1'b0;
      o_pc_wen       = 1'b0;
      o_calc_bj_addr = 1'b0;
      o_rf_wen       = 1'b0;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and randomized self-checking bench for control_unit
module tb_control_unit;
  localparam int C_OP = 0, C_OPI = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5, C_LUI = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        o_imem_req, i_imem_ack, o_pc_wen, o_calc_bj_addr, o_imm_sel, i_alu_zero;
  logic        o_rf_wen, o_dmem_req, o_dmem_we, i_dmem_ack, o_illegal;
  logic [31:0] i_imem_rdata, o_immediate;
  logic [3:0]  o_alu_op;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [1:0]  o_wb_sel;
  logic [2:0]  o_mem_funct3;

  int checks = 0;
  int errors = 0;
  int qcnt;

  logic [31:0] e_ins, e_imm;
  int          e_cls;
  logic [4:0]  e_rd, e_rs1, e_rs2;
  logic [2:0]  e_f3;
  logic [3:0]  e_alu;

  logic [6:0] opc_tab [7]  = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h37};
  logic [2:0] op_f3   [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
  logic [6:0] op_f7   [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
  logic [3:0] op_alu  [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  logic [3:0] opi_alu [8]  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
  logic [2:0] ld_f3   [5]  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] br_f3   [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  control_unit #(.XLEN(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .o_imem_req     (o_imem_req),
    .i_imem_ack     (i_imem_ack),
    .i_imem_rdata   (i_imem_rdata),
    .o_pc_wen       (o_pc_wen),
    .o_calc_bj_addr (o_calc_bj_addr),
    .o_imm_sel      (o_imm_sel),
    .o_immediate    (o_immediate),
    .o_alu_op       (o_alu_op),
    .i_alu_zero     (i_alu_zero),
    .o_rs1_addr     (o_rs1_addr),
    .o_rs2_addr     (o_rs2_addr),
    .o_rd_addr      (o_rd_addr),
    .o_rf_wen       (o_rf_wen),
    .o_wb_sel       (o_wb_sel),
    .o_dmem_req     (o_dmem_req),
    .o_dmem_we      (o_dmem_we),
    .o_mem_funct3   (o_mem_funct3),
    .i_dmem_ack     (i_dmem_ack),
    .o_illegal      (o_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // assemble an instruction from abstract fields and record what the decoder must report
  task automatic prep(input int cls, input int sub, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input int imm);
    logic [31:0] v;
    logic [6:0]  opc;
    logic [2:0]  f3;
    v = imm;
    opc = opc_tab[cls];
    f3 = (cls == C_OP) ? op_f3[sub] : 3'(sub);
    e_cls = cls; e_rd = rd; e_rs1 = rs1; e_rs2 = rs2; e_f3 = f3; e_imm = v; e_alu = 4'd0;
    case (cls)
      C_OP: begin
        e_ins = {op_f7[sub], rs2, rs1, f3, rd, opc};
        e_alu = op_alu[sub];
      end
      C_OPI: begin
        e_ins = {v[11:0], rs1, f3, rd, opc};
        e_alu = (f3 == 3'd5 && v[10]) ? 4'd7 : opi_alu[f3];
      end
      C_LD:  e_ins = {v[11:0], rs1, f3, rd, opc};
      C_ST:  e_ins = {v[11:5], rs2, rs1, f3, v[4:0], opc};
      C_BR: begin
        e_ins = {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], opc};
        e_alu = (f3 < 3'd2) ? 4'd1 : (f3 < 3'd6) ? 4'd3 : 4'd4;
      end
      C_JAL: e_ins = {v[20], v[10:1], v[11], v[19:12], rd, opc};
      default: e_ins = {v[31:12], rd, opc};
    endcase
  endtask

  task automatic rand_prep();
    int cls = int'($urandom_range(0, 6));
    int sub = 0;
    int imm = 0;
    case (cls)
      C_OP: sub = int'($urandom_range(0, 9));
      C_OPI: begin
        sub = int'($urandom_range(0, 7));
        if (sub == 1) imm = int'($urandom_range(0, 31));
        else if (sub == 5) imm = int'($urandom_range(0, 31)) + ($urandom_range(0, 1) != 0 ? 1024 : 0);
        else imm = int'($urandom_range(0, 4095)) - 2048;
      end
      C_LD: begin
        sub = int'(ld_f3[$urandom_range(0, 4)]);
        imm = int'($urandom_range(0, 4095)) - 2048;
      end
      C_ST: begin
        sub = int'($urandom_range(0, 2));
        imm = int'($urandom_range(0, 4095)) - 2048;
      end
      C_BR: begin
        sub = int'(br_f3[$urandom_range(0, 5)]);
        imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
      end
      C_JAL: imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      default: imm = int'($urandom_range(0, 1048575)) << 12;
    endcase
    prep(cls, sub, 5'($urandom), 5'($urandom), 5'($urandom), imm);
  endtask

  // run one instruction from its FETCH cycle to the next FETCH with the given memory latencies
  task automatic run_instr(input int iw, input int dw, input logic z);
    int   cyc = 0, ireq = 0, dreq = 0, pcw = 0, rfw = 0, since = -1, ecyc;
    logic calc = 0, we = 0, on_ack = 0, done = 0, wr, mem, toz, ecalc;
    logic [1:0] wb = 0, ewb;
    logic [4:0] rd = 0;
    logic [2:0] f3 = 0;
    wr    = (e_cls inside {C_OP, C_OPI, C_LD, C_JAL, C_LUI}) && e_rd != 5'd0;
    mem   = e_cls inside {C_LD, C_ST};
    toz   = e_f3 inside {3'd0, 3'd5, 3'd7};
    ecalc = (e_cls == C_BR) ? (toz ? z : !z) : (e_cls == C_JAL);
    ewb   = (e_cls == C_LD) ? 2'd1 : (e_cls == C_JAL) ? 2'd2 : (e_cls == C_LUI) ? 2'd3 : 2'd0;
    ecyc  = iw + 3 + ((e_cls == C_LD) ? dw + 2 : (e_cls == C_ST) ? dw + 1 : 1);
    while (!done && cyc < 64) begin
      i_alu_zero   = z;
      i_imem_ack   = o_imem_req ? (ireq == iw) : 1'($urandom_range(0, 1));
      i_imem_rdata = (o_imem_req && ireq == iw) ? e_ins : $urandom;
      i_dmem_ack   = o_dmem_req ? (dreq == dw) : 1'($urandom_range(0, 1));
      #1;
      if (since == 1) begin
        chk("alu_op", 32'(o_alu_op), 32'(e_alu));
        chk("imm_sel", 32'(o_imm_sel), 32'(!(e_cls inside {C_OP, C_BR})));
        if (e_cls != C_OP) chk("immediate", o_immediate, e_imm);
        if (!(e_cls inside {C_JAL, C_LUI})) chk("rs1", 32'(o_rs1_addr), 32'(e_rs1));
        if (e_cls inside {C_OP, C_ST, C_BR}) chk("rs2", 32'(o_rs2_addr), 32'(e_rs2));
      end
      if (o_imem_req) ireq++;
      if (o_dmem_req) begin dreq++; we = o_dmem_we; f3 = o_mem_funct3; end
      if (o_rf_wen) begin rfw++; wb = o_wb_sel; rd = o_rd_addr; end
      if (o_pc_wen) begin
        pcw++;
        calc = o_calc_bj_addr;
        on_ack = o_dmem_req && i_dmem_ack;
        done = 1'b1;
      end
      if (since >= 0) since++;
      if (o_imem_req && i_imem_ack) since = 0;
      cyc++;
      @(posedge clk); #1;
    end
    i_imem_ack = 1'b0;
    i_dmem_ack = 1'b0;
    chk("retired", 32'(done), 32'd1);
    chk("cycles", cyc, ecyc);
    chk("imem_req_cycles", ireq, iw + 1);
    chk("dmem_req_cycles", dreq, mem ? dw + 1 : 0);
    chk("pc_wen_pulses", pcw, 1);
    chk("calc_bj_addr", 32'(calc), 32'(ecalc));
    chk("pc_wen_on_dmem_ack", 32'(on_ack), 32'(e_cls == C_ST));
    chk("rf_wen_pulses", rfw, 32'(wr));
    if (wr) begin
      chk("wb_sel", 32'(wb), 32'(ewb));
      chk("rd", 32'(rd), 32'(e_rd));
    end
    if (mem) begin
      chk("dmem_we", 32'(we), 32'(e_cls == C_ST));
      chk("mem_funct3", 32'(f3), 32'(e_f3));
    end
    chk("next_fetch_req", 32'(o_imem_req), 32'd1);
    chk("illegal_clear", 32'(o_illegal), 32'd0);
  endtask

  initial begin
    i_imem_ack = 1'b0; i_imem_rdata = '0; i_dmem_ack = 1'b0; i_alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", 32'(o_imem_req), 32'd0);
    chk("rst_dmem_req", 32'(o_dmem_req), 32'd0);
    chk("rst_strobes", 32'({o_pc_wen, o_rf_wen, o_dmem_we}), 32'd0);
    chk("rst_illegal", 32'(o_illegal), 32'd0);
    rstn = 1'b1;
    #1;
    chk("first_fetch_req", 32'(o_imem_req), 32'd1);
    chk("nop_immediate", o_immediate, 32'd0);
    chk("nop_rd", 32'(o_rd_addr), 32'd0);
    chk("nop_alu_op", 32'(o_alu_op), 32'd0);
    chk("nop_imm_sel", 32'(o_imm_sel), 32'd1);

    prep(C_OPI, 0, 5'd1, 5'd0, 5'd0, 5);
    run_instr(0, 0, 1'b0);
    prep(C_BR, 0, 5'd0, 5'd0, 5'd0, 8);
    run_instr(0, 0, 1'b1);
    prep(C_BR, 1, 5'd0, 5'd0, 5'd0, 8);
    run_instr(0, 0, 1'b1);
    prep(C_LD, 2, 5'd2, 5'd1, 5'd0, 4);
    run_instr(3, 2, 1'b0);
    prep(C_ST, 2, 5'd0, 5'd1, 5'd2, 8);
    run_instr(0, 0, 1'b0);
    prep(C_JAL, 0, 5'd1, 5'd0, 5'd0, -2048);
    run_instr(1, 0, 1'b0);
    prep(C_LUI, 0, 5'd5, 5'd0, 5'd0, 32'h8765_4000);
    run_instr(0, 0, 1'b0);
    prep(C_OPI, 5, 5'd3, 5'd4, 5'd0, 1024 + 7);
    run_instr(0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      rand_prep();
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    i_imem_rdata = 32'hFFFF_FFFF;
    i_imem_ack = 1'b1;
    @(posedge clk); #1;
    i_imem_ack = 1'b0;
    @(posedge clk); #1;
    #1;
    chk("trap_illegal", 32'(o_illegal), 32'd1);
    qcnt = 0;
    repeat (6) begin
      i_imem_ack = 1'($urandom_range(0, 1));
      i_dmem_ack = 1'($urandom_range(0, 1));
      #1;
      if (o_imem_req || o_pc_wen || o_rf_wen || o_dmem_req) qcnt++;
      @(posedge clk); #1;
    end
    chk("trap_quiet", qcnt, 0);
    chk("illegal_sticky", 32'(o_illegal), 32'd1);
    rstn = 1'b0; i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    chk("trap_reset_req", 32'(o_imem_req), 32'd1);
    chk("trap_reset_illegal", 32'(o_illegal), 32'd0);

    prep(C_ST, 2, 5'd0, 5'd1, 5'd2, 8);
    i_imem_rdata = e_ins;
    i_imem_ack = 1'b1;
    @(posedge clk); #1;
    i_imem_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #1;
    chk("mem_dmem_req", 32'(o_dmem_req), 32'd1);
    chk("mem_dmem_we", 32'(o_dmem_we), 32'd1);
    chk("sw_immediate", o_immediate, 32'd8);
    rstn = 1'b0;
    i_dmem_ack = 1'b1;
    #1;
    chk("rst_mem_pc_wen", 32'(o_pc_wen), 32'd0);
    chk("rst_mem_rf_wen", 32'(o_rf_wen), 32'd0);
    @(posedge clk); #1;
    chk("rst_mem_dmem_req", 32'(o_dmem_req), 32'd0);
    chk("rst_mem_pc_wen_next", 32'(o_pc_wen), 32'd0);
    rstn = 1'b1;
    i_dmem_ack = 1'b0;
    #1;
    chk("post_rst_dmem_req", 32'(o_dmem_req), 32'd0);
    chk("post_rst_imem_req", 32'(o_imem_req), 32'd1);
    chk("post_rst_ir_imm", o_immediate, 32'd0);
    chk("post_rst_ir_funct3", 32'(o_mem_funct3), 32'd0);
    chk("post_rst_ir_rs2", 32'(o_rs2_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
